sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, synchronous first-in/first-out buffer for byte-wide data, used between producer and consumer blocks (e.g. a command source feeding a UART transmitter) in the same clock domain. Writes and reads are request/acknowledge transactions: the requester holds an enable, and the FIFO returns a one-cycle acknowledge for every accepted transfer. Status flags report full and empty, and a read returns its word on a registered output.

## Interface
- WIDTH, 8: data word width in bits.
- DEPTH, 16: number of storage words; power of two, at least 2. Pointer width AW = log2(DEPTH); occupancy counter width AW+1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; clears the FIFO immediately on assertion.
- data_i  input  WIDTH  write data, sampled on the edge that accepts a write.
- en_r  input  1  read request, level, sampled each rising edge.
- en_w  input  1  write request, level, sampled each rising edge.
- data_o  output  WIDTH  registered read data, updated only by an accepted read.
- full  output  1  high when the occupancy equals DEPTH.
- empty  output  1  high when the occupancy equals 0.
- ack_r  output  1  one-cycle pulse; high in the cycle after an accepted read.
- ack_w  output  1  one-cycle pulse; high in the cycle after an accepted write.

## Operation
- State: storage array of DEPTH×WIDTH, write pointer wp, read pointer rp (both AW bits, wrap modulo DEPTH), occupancy count (0..DEPTH).
- Write accepted when en_w=1 and full=0. mem[wp] <= data_i, wp <= wp+1.
- Read accepted when en_r=1 and empty=0. data_o <= mem[rp], rp <= rp+1.
- Simultaneous accepted read and write: both occur and count is unchanged. Reading and writing the same slot is impossible because a read requires count ≥ 1.
- A write while full is rejected even if a read is accepted on the same edge. A read while empty is rejected even if a write is accepted on the same edge. A rejected request:
  - produces no acknowledge;
  - changes no state;
  - leaves data_o holding its last value.
- count: +1 on write only, −1 on read only. full and empty are registered and derived from the next count value, so they are valid in the same cycle as the acks.
- A requester holding en_w or en_r high gets one transfer per cycle while the request remains acceptable.
- Reset (rst=0):
  - wp, rp and count are cleared to 0;
  - data_o = 0, ack_r = 0, ack_w = 0, empty = 1, full = 0;
  - storage contents are governed by Configuration.
- Reset asserted mid-operation discards all stored words. No acks are emitted for the edge coinciding with reset.

## Timing
- Write latency: word accepted at edge N is readable (empty=0) after edge N and can be read at edge N+1.
- Read latency: data_o and ack_r are valid in the cycle following the accepting edge, i.e. one cycle.
- ack_w and ack_r are each high for exactly one cycle per accepted transfer. Back-to-back transfers give a continuously high ack.
- Flags change only on clock edges or on reset assertion. There are no combinational paths from inputs to outputs.
- Throughput: one write and one read per cycle.

## Configuration
- FIFO_MEM_CLEAR_EN defined: reset also clears every storage word to 0, so the array is fully flop-based and deterministic.
- FIFO_MEM_CLEAR_EN undefined: the storage array is not reset and may map to RAM. Contents are undefined until written. The externally observable behaviour is identical, because empty slots are never read.

## Test plan
- Reset: assert rst=0 mid-stream -> immediately empty=1, full=0, data_o=0, ack_r=ack_w=0. After release, a read with en_r=1 yields no ack_r.
- Fill/drain (DEPTH=16): write 0x00..0x0F -> 16 ack_w pulses, full=1 after the 16th. Then read 16 times -> data_o = 0x00..0x0F in order, empty=1 after the last.
- Overflow: when full, write 0xAA -> no ack_w. Drain -> 0xAA never appears and the count stays 16 until the first read.
- Underflow: when empty, set en_r=1 for 3 cycles -> no ack_r, data_o holds its previous value, empty stays 1.
- Simultaneous: with count=5, set en_r=en_w=1 for 20 cycles -> ack_r and ack_w continuous, full=0 and empty=0 throughout. Data order is preserved across pointer wrap-around.
- Boundaries: with count=0, en_r=en_w=1 -> write only, and count becomes 1. With count=16, en_r=en_w=1 -> read only, and count becomes 15.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with request/acknowledge handshakes and registered flags.
// Define FIFO_MEM_CLEAR_EN to reset the storage array as well as the control state.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   input  logic             en_r,
   input  logic             en_w,
   output logic [WIDTH-1:0] data_o,
   output logic             full,
   output logic             empty,
   output logic             ack_r,
   output logic             ack_w
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             ack_r_q, ack_r_d;
   logic             ack_w_q, ack_w_d;
   logic             wr_acc, rd_acc;

   // Acceptance uses the registered flags, so a full FIFO refuses a write
   // even when a read frees a slot on the same edge (and vice versa).
   assign wr_acc = en_w & ~full_q;
   assign rd_acc = en_r & ~empty_q;

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      ack_w_d = wr_acc;
      ack_r_d = rd_acc;
      if (wr_acc) begin
         wp_d = wp_q + PTR_ONE;
      end
      if (rd_acc) begin
         rp_d   = rp_q + PTR_ONE;
         data_d = mem_q[rp_q];
      end
      if (wr_acc && !rd_acc) begin
         cnt_d = cnt_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
         cnt_d = cnt_q - CNT_ONE;
      end
      full_d  = (cnt_d == FULL_CNT);
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         ack_r_q <= 1'b0;
         ack_w_q <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         full_q  <= full_d;
         empty_q <= empty_d;
         ack_r_q <= ack_r_d;
         ack_w_q <= ack_w_d;
      end
   end

`ifdef FIFO_MEM_CLEAR_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_acc) begin
         mem_q[wp_q] <= data_i;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wp_q] <= data_i;
      end
   end
`endif

   assign data_o = data_q;
   assign full   = full_q;
   assign empty  = empty_q;
   assign ack_r  = ack_r_q;
   assign ack_w  = ack_w_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_sync_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data_i;
   logic             en_r;
   logic             en_w;
   logic [WIDTH-1:0] data_o;
   logic             full;
   logic             empty;
   logic             ack_r;
   logic             ack_w;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .data_i (data_i),
      .en_r   (en_r),
      .en_w   (en_w),
      .data_o (data_o),
      .full   (full),
      .empty  (empty),
      .ack_r  (ack_r),
      .ack_w  (ack_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected packing: {data_o, ack_w, ack_r, full, empty}
   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] d;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl [9];

   int vectors;
   int miscompares;

   logic [7:0] mq [$];
   logic [7:0] m_data;
   logic       m_ackw, m_ackr;

   function automatic logic [11:0] model_out();
      return {m_data, m_ackw, m_ackr, (mq.size() == DEPTH), (mq.size() == 0)};
   endfunction

   task automatic check(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {data_o, ack_w, ack_r, full, empty};
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got data=%02h ackw=%b ackr=%b full=%b empty=%b, want data=%02h ackw=%b ackr=%b full=%b empty=%b",
                  name, act[11:4], act[3], act[2], act[1], act[0],
                  exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // One clock: drive requests, advance the model, compare after the edge.
   task automatic step(input logic w, input logic r, input logic [7:0] d, input string name);
      bit wacc, racc;
      en_w   = w;
      en_r   = r;
      data_i = d;
      wacc = w && (mq.size() < DEPTH);
      racc = r && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (racc) m_data = mq.pop_front();
      if (wacc) mq.push_back(d);
      m_ackw = wacc;
      m_ackr = racc;
      check(name, model_out());
   endtask

   task automatic model_reset();
      mq.delete();
      m_data = '0;
      m_ackw = 1'b0;
      m_ackr = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      //            w     r     d       data   aw    ar    f     e
      tbl[0] = '{1'b0, 1'b1, 8'h00, {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[1] = '{1'b1, 1'b0, 8'h11, {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[2] = '{1'b1, 1'b0, 8'h22, {8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[3] = '{1'b1, 1'b1, 8'h33, {8'h11, 1'b1, 1'b1, 1'b0, 1'b0}};
      tbl[4] = '{1'b0, 1'b1, 8'h00, {8'h22, 1'b0, 1'b1, 1'b0, 1'b0}};
      tbl[5] = '{1'b0, 1'b1, 8'h00, {8'h33, 1'b0, 1'b1, 1'b0, 1'b1}};
      tbl[6] = '{1'b0, 1'b1, 8'h00, {8'h33, 1'b0, 1'b0, 1'b0, 1'b1}};
      tbl[7] = '{1'b1, 1'b1, 8'h44, {8'h33, 1'b1, 1'b0, 1'b0, 1'b0}};
      tbl[8] = '{1'b0, 1'b1, 8'h00, {8'h44, 1'b0, 1'b1, 1'b0, 1'b1}};

      rst    = 1'b0;
      en_r   = 1'b0;
      en_w   = 1'b0;
      data_i = '0;
      model_reset();
      @(posedge clk);
      #1;
      check("reset_state", {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      rst = 1'b1;

      // Directed table
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].w, tbl[i].r, tbl[i].d, $sformatf("table_%0d_model", i));
         check($sformatf("table_%0d", i), tbl[i].exp);
      end

      // Fill 0x00..0x0F
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), $sformatf("fill_%0d", i));
      check("full_after_fill", {8'h44, 1'b1, 1'b0, 1'b1, 1'b0});

      // Overflow: 0xAA rejected, full holds
      step(1'b1, 1'b0, 8'hAA, "overflow_reject");
      check("overflow_noack", {8'h44, 1'b0, 1'b0, 1'b1, 1'b0});
      step(1'b1, 1'b0, 8'hAA, "overflow_hold");

      // Boundary at full: read+write -> read only, count 15
      step(1'b1, 1'b1, 8'hAA, "full_rw_boundary");
      check("full_rw_readonly", {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});

      // Drain the rest
      for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, $sformatf("drain_%0d", i));
      check("empty_after_drain", {8'h0F, 1'b0, 1'b1, 1'b0, 1'b1});

      // Underflow: three idle reads
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00, $sformatf("underflow_%0d", i));
      check("underflow_hold", {8'h0F, 1'b0, 1'b0, 1'b0, 1'b1});

      // Simultaneous traffic at count=5 across pointer wrap
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h50 + i), $sformatf("pre5_%0d", i));
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 8'(8'h60 + i), $sformatf("simul_%0d", i));
         check($sformatf("simul_acks_%0d", i),
               {data_o, 1'b1, 1'b1, 1'b0, 1'b0});
      end

      // Mid-stream asynchronous reset
      en_w = 1'b1; en_r = 1'b0; data_i = 8'h77;
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check("async_reset_immediate", {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      #1;
      check("reset_held_edge", {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
      rst = 1'b1;
      step(1'b0, 1'b1, 8'h00, "post_reset_read");
      check("post_reset_noack", {8'h00, 1'b0, 1'b0, 1'b0, 1'b1});

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic w, r;
         int unsigned bias;
         bias = (i / 500) % 3;
         w = ($urandom_range(0, 9) < (bias == 0 ? 7 : (bias == 1 ? 3 : 5)));
         r = ($urandom_range(0, 9) < (bias == 0 ? 3 : (bias == 1 ? 7 : 5)));
         step(w, r, 8'($urandom), "random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
